// File: rtl/multiplier_s_c1x2_f1_16bits_8bits.sv
// Fracturable 16x8 multiplier slice with a registered 24-bit result.
// It runs either as one full 16x8 product (HALF_0) or as two independent
// 8x4 lane products packed side by side (HALF_1). Each operand can be
// signed or unsigned, selected at run time.
//
// One partial-product array serves both modes. Each of the eight rows
// belongs to one bit of B:
//   - Full mode: row j is the 24-bit sign/zero-extended A, shifted left by j.
//   - Half mode: rows 0..3 carry the low A lane, placed in the low 12 bits.
//     Rows 4..7 carry the high A lane, placed in the high 12 bits.
//     Each lane row is shifted only within its own lane.
//   - The row at the MSB of a signed B operand enters negated, because that
//     bit carries a negative weight. In half mode the negation is done in
//     12-bit lane arithmetic, so it never spills into the other lane.
//   - The rows are summed as separate low and high 12-bit column groups.
//     The low-group carry is added back only in full mode; in half mode it
//     is simply dropped at the C[11]/C[12] boundary.
module multiplier_s_c1x2_f1_16bits_8bits #(
  parameter int A_chop_size = 16,
  parameter int B_chop_size = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [A_chop_size-1:0] A,
  input  logic [B_chop_size-1:0] B,
  input  logic                   A_sign,
  input  logic                   B_sign,
  input  logic                   HALF_0,
  input  logic                   HALF_1,
  output logic [23:0]            C
);

  logic        half_mode;
  logic [23:0] a_full;
  logic [11:0] a_hi;
  logic [11:0] a_lo;
  logic [23:0] pp [8];
  logic [23:0] lo_sum;
  logic [11:0] hi_sum;
  logic [23:0] full_res;
  logic [23:0] half_res;

  // HALF_0 has priority, so the dual-lane layout is used only when it is low.
  assign half_mode = !HALF_0 && HALF_1;

  // Operands extended to the width of the product they feed.
  assign a_full = {{8{A_sign & A[15]}}, A};
  assign a_hi   = {{4{A_sign & A[15]}}, A[15:8]};
  assign a_lo   = {{4{A_sign & A[7]}}, A[7:0]};

  for (genvar j = 0; j < 8; j++) begin : g_pp
    localparam int LANE_SHIFT = j % 4;
    localparam bit HI_LANE    = (j >= 4);
    localparam bit LANE_MSB   = (LANE_SHIFT == 3);
    localparam bit FULL_MSB   = (j == 7);

    logic [23:0] full_shift;
    logic [23:0] full_row;
    logic [11:0] lane_op;
    logic [11:0] lane_shift;
    logic [11:0] lane_row;

    assign full_shift = B[j] ? (a_full << j) : 24'd0;
    assign full_row   = (FULL_MSB && B_sign) ? -full_shift : full_shift;
    assign lane_op    = HI_LANE ? a_hi : a_lo;
    assign lane_shift = B[j] ? (lane_op << LANE_SHIFT) : 12'd0;
    assign lane_row   = (LANE_MSB && B_sign) ? -lane_shift : lane_shift;
    assign pp[j]      = half_mode ? (HI_LANE ? {lane_row, 12'd0} : {12'd0, lane_row})
                                  : full_row;
  end

  // Reduce the rows as independent low/high column groups so the lanes stay isolated.
  always_comb begin
    lo_sum = 24'd0;
    hi_sum = 12'd0;
    for (int j = 0; j < 8; j++) begin
      lo_sum = lo_sum + {12'd0, pp[j][11:0]};
      hi_sum = hi_sum + pp[j][23:12];
    end
  end

  assign full_res = {hi_sum, 12'd0} + lo_sum;
  assign half_res = {hi_sum, lo_sum[11:0]};

  // Output register loads every cycle; an idle mode clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C <= 24'd0;
    end else if (HALF_0) begin
      C <= full_res;
    end else if (HALF_1) begin
      C <= half_res;
    end else begin
      C <= 24'd0;
    end
  end

endmodule

// File: tb/tb_multiplier_s_c1x2_f1_16bits_8bits.sv
// Testbench for the fracturable 16x8 multiplier slice. It drives directed
// vectors, random sweeps with per-cycle mode changes, and reset sequences,
// and compares C against an arithmetic reference model.
module tb_multiplier_s_c1x2_f1_16bits_8bits;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  b;
  logic        a_sign;
  logic        b_sign;
  logic        half_0;
  logic        half_1;
  logic [23:0] c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  b;
    logic        as;
    logic        bs;
    logic        h0;
    logic        h1;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [10];

  multiplier_s_c1x2_f1_16bits_8bits #(
    .A_chop_size(16),
    .B_chop_size(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (a),
    .B      (b),
    .A_sign (a_sign),
    .B_sign (b_sign),
    .HALF_0 (half_0),
    .HALF_1 (half_1),
    .C      (c)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Interprets the low w bits of v as unsigned or as two's complement.
  function automatic longint sval(input logic [15:0] v, input int w, input logic sg);
    longint u;
    u = longint'(v) & ((longint'(1) << w) - 1);
    if (sg && u >= (longint'(1) << (w - 1))) u = u - (longint'(1) << w);
    return u;
  endfunction

  // Reference model: plain integer products, truncated to the field widths.
  function automatic logic [23:0] model(input logic [15:0] ma, input logic [7:0] mb,
                                        input logic as, input logic bs,
                                        input logic h0, input logic h1);
    longint      p;
    longint      ph;
    longint      pl;
    logic [63:0] t;
    logic [63:0] th;
    logic [63:0] tl;
    if (h0) begin
      p = sval(ma, 16, as) * sval({8'd0, mb}, 8, bs);
      t = p;
      return t[23:0];
    end else if (h1) begin
      ph = sval({8'd0, ma[15:8]}, 8, as) * sval({12'd0, mb[7:4]}, 4, bs);
      pl = sval({8'd0, ma[7:0]}, 8, as) * sval({12'd0, mb[3:0]}, 4, bs);
      th = ph;
      tl = pl;
      return {th[11:0], tl[11:0]};
    end
    return 24'd0;
  endfunction

  // Drives one operation before a rising edge and returns just after that edge.
  task automatic applyStimulus(input logic [15:0] ta, input logic [7:0] tb,
                               input logic as, input logic bs,
                               input logic h0, input logic h1);
    @(negedge clk);
    a      = ta;
    b      = tb;
    a_sign = as;
    b_sign = bs;
    half_0 = h0;
    half_1 = h1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [23:0] exp);
    checks++;
    if (c !== exp) begin
      errors++;
      $display("[TB] FAIL %s: C=%h expected %h (A=%h B=%h as=%0b bs=%0b h0=%0b h1=%0b)",
               name, c, exp, a, b, a_sign, b_sign, half_0, half_1);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic        ras;
    logic        rbs;
    logic        rh0;
    logic        rh1;

    vecs[0] = '{"unsigned_full_max",  16'hFFFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 24'hFEFF01};
    vecs[1] = '{"signed_full_min",    16'h8000, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 24'h400000};
    vecs[2] = '{"signed_full_neg",    16'hFFFF, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFE};
    vecs[3] = '{"unsigned_dual",      16'hFF0F, 8'hF3, 1'b0, 1'b0, 1'b0, 1'b1, 24'hEF102D};
    vecs[4] = '{"signed_dual",        16'h80FF, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 24'hC80001};
    vecs[5] = '{"half0_priority",     16'h0003, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 24'h00000F};
    vecs[6] = '{"idle_clears",        16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[7] = '{"mixed_full",         16'hFFFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFF01};
    vecs[8] = '{"signed_dual_min",    16'h8080, 8'h88, 1'b1, 1'b1, 1'b0, 1'b1, 24'h400400};
    vecs[9] = '{"mixed_dual",         16'h0102, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b1, 24'hFFFFF0};

    // Reset is held across several edges with an active operation on the inputs.
    rst_n  = 1'b0;
    a      = 16'h0003;
    b      = 8'h05;
    a_sign = 1'b0;
    b_sign = 1'b0;
    half_0 = 1'b1;
    half_1 = 1'b0;
    #1;
    checkOutput("reset_initial", 24'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", 24'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one per cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].h0, vecs[i].h1);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Random sweep: 100 operations for each mode and sign combination.
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 100; i++) begin
          ra  = 16'($urandom);
          rb  = 8'($urandom);
          ras = s[1];
          rbs = s[0];
          rh0 = (m == 0);
          rh1 = (m == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          applyStimulus(ra, rb, ras, rbs, rh0, rh1);
          checkOutput("rand_sweep", model(ra, rb, ras, rbs, rh0, rh1));
        end
      end
    end

    // Random sweep with mode and sign changing every cycle.
    for (int i = 0; i < 300; i++) begin
      ra  = 16'($urandom);
      rb  = 8'($urandom);
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      rh0 = 1'($urandom_range(0, 1));
      rh1 = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, ras, rbs, rh0, rh1);
      checkOutput("rand_switch", model(ra, rb, ras, rbs, rh0, rh1));
    end

    // Reset asserted mid-stream clears C without waiting for a clock edge.
    applyStimulus(16'h1234, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset", 24'h061D78);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 24'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 24'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    a      = 16'h0003;
    b      = 8'h05;
    half_0 = 1'b0;
    half_1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 24'd0);
    applyStimulus(16'h0003, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("first_after_reset", 24'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_s_c1x2_f1_16bits_8bits.md
# multiplier_s_c1x2_f1_16bits_8bits

Precision-configurable 16x8 integer multiplier with a registered output, used as a fracturable multiplier slice in the DSP-block datapath. It runs either as one full 16x8 multiply, or as two independent 8x4 multiplies packed into the same 24-bit result. Operand signedness is selected per operand at run time.

## Interface
Parameters:
- A_chop_size, 16, width of operand A (fixed; other values unsupported)
- B_chop_size, 8, width of operand B (fixed; other values unsupported)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- A  input  16  multiplicand; full mode uses A[15:0]; half mode uses lanes A[15:8] and A[7:0]
- B  input  8  multiplier; full mode uses B[7:0]; half mode uses lanes B[7:4] and B[3:0]
- A_sign  input  1  1 = A (each A lane) is two's complement; 0 = unsigned
- B_sign  input  1  1 = B (each B lane) is two's complement; 0 = unsigned
- HALF_0  input  1  mode select: full-precision 16x8
- HALF_1  input  1  mode select: dual 8x4
- C  output  24  registered product(s)

## Operation
- Full mode (HALF_0=1, any HALF_1):
  - C[23:0] = A[15:0] x B[7:0], exact 24-bit product.
  - Each operand is interpreted per its sign bit.
  - HALF_0 has priority over HALF_1.
- Half mode (HALF_0=0, HALF_1=1):
  - C[23:12] = A[15:8] x B[7:4].
  - C[11:0] = A[7:0] x B[3:0].
  - Each lane is an exact 12-bit product.
  - Lane operands are interpreted signed/unsigned per A_sign/B_sign, sign bit at each lane MSB (A[15], A[7], B[7], B[3]).
  - No carry or sign extension crosses the C[11]/C[12] boundary.
- Idle (HALF_0=0, HALF_1=0): next C = 0.
- Mixed signedness (A_sign≠B_sign) is supported in both modes: signed x unsigned, product in two's complement.
- Full-mode result width:
  - Signed 16x8 fits 24 bits, including -32768 x -128 = +4194304.
  - Unsigned max is 0xFEFF01.
- Half-mode lane width: signed 8x4 extremes fit 12 bits (-128 x -8 = 1024).
- Implementation: a shared partial-product array with mode-dependent masking of cross-lane partial products and Baugh-Wooley style sign handling is preferred. Any structure that produces exact results is acceptable.

## Timing
- Single register stage on C; latency 1 cycle.
- Inputs sampled on rising edge N appear on C after edge N and hold until edge N+1.
- Throughput: one new operation per cycle; mode and sign controls may change every cycle with no bubbles.
- C during rst_n=0: forced to 0 asynchronously.
- First valid result appears on the first rising edge after rst_n deasserts.
- No handshake, no enable: the register loads every cycle.

## Test plan
- Unsigned full: A=0xFFFF, B=0xFF, A_sign=B_sign=0, HALF_0=1, HALF_1=0 -> C=0xFEFF01 one cycle later.
- Signed full:
  - A=0x8000, B=0x80, signs=1 -> C=0x400000.
  - A=0xFFFF, B=0x02 -> C=0xFFFFFE.
- Unsigned dual: A=0xFF0F, B=0xF3, signs=0, HALF_0=0, HALF_1=1 -> C=0xEF102D (255x15 and 15x3).
- Signed dual: A=0x80FF, B=0x7F, signs=1, HALF_0=0, HALF_1=1 -> C=0xC80001 (-128x7=-896 and -1x-1=1).
- Random sweeps: 100 random A/B per mode/sign combination, back-to-back one per cycle, checked against a behavioural model. Mode switches between consecutive cycles must yield correct results with no errors.
- Reset and idle:
  - Assert rst_n=0 mid-stream -> C=0 immediately.
  - After release, HALF_0=HALF_1=0 -> C stays 0.
  - A then HALF_0=1 with A=3, B=5 -> C=15 next cycle.
